// File: rtl/nothing_paced.sv
// ---------------------------------------------------------------------------
// nothing_paced
//
// Elastic pacing stage. Bursts of samples (in_nd strobes) are buffered in a
// small circular FIFO and re-emitted in arrival order with at least SPACING
// cycles between consecutive out_nd pulses. Data and metadata travel through
// unchanged. With SPACING=1 the block behaves as a one-cycle registered
// pass-through and the buffer is never used.
//
// Parameters
//   WDTH       data width
//   MWDTH      metadata width
//   LOG_DEPTH  log2 of buffer depth
//   DEPTH      buffer entries (must equal 2**LOG_DEPTH)
//   SPACING    minimum cycles between out_nd pulses (1..255)
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_data    input sample, valid with in_nd
//   in_nd      new-data strobe (no backpressure)
//   in_m       metadata accompanying in_data
//   out_data   registered output sample
//   out_nd     one-cycle strobe per emitted sample
//   out_m      metadata accompanying out_data
//   out_count  number of samples currently held in the buffer
//   error      sticky overflow flag, cleared only by rst
// ---------------------------------------------------------------------------
module nothing_paced #(
    parameter int WDTH      = 32,
    parameter int MWDTH     = 1,
    parameter int LOG_DEPTH = 3,
    parameter int DEPTH     = 8,
    parameter int SPACING   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WDTH-1:0]      in_data,
    input  logic                 in_nd,
    input  logic [MWDTH-1:0]     in_m,
    output logic [WDTH-1:0]      out_data,
    output logic                 out_nd,
    output logic [MWDTH-1:0]     out_m,
    output logic [LOG_DEPTH:0]   out_count,
    output logic                 error
);

    localparam logic [LOG_DEPTH:0]   FULL_COUNT = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]   COUNT_ONE  = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);
    localparam logic [7:0]           GAP_RELOAD = 8'(SPACING - 1);

    // Buffer storage; contents need no reset because count/pointers define
    // which entries are meaningful.
    logic [WDTH-1:0]      mem_data_q [DEPTH];
    logic [MWDTH-1:0]     mem_m_q    [DEPTH];

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   count_q,  count_d;
    logic [7:0]           gap_q,    gap_d;
    logic [WDTH-1:0]      out_data_q, out_data_d;
    logic [MWDTH-1:0]     out_m_q,    out_m_d;
    logic                 out_nd_q,   out_nd_d;
    logic                 error_q,    error_d;

    logic                 fire;
    logic                 buf_rd;
    logic                 bypass;
    logic                 full;
    logic                 wr_en;

    always_comb begin
        fire   = (gap_q == 8'd0) && ((count_q != '0) || in_nd);
        buf_rd = fire && (count_q != '0);
        // Bypass only when the buffer is empty, which keeps strict FIFO order.
        bypass = fire && (count_q == '0);
        full   = (count_q == FULL_COUNT);
        // A full buffer still accepts a write when the head leaves this cycle.
        wr_en  = in_nd && !bypass && (!full || buf_rd);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        gap_d      = gap_q;
        out_data_d = out_data_q;
        out_m_d    = out_m_q;
        out_nd_d   = 1'b0;
        error_d    = error_q;

        if (fire) begin
            out_nd_d = 1'b1;
            gap_d    = GAP_RELOAD;
            if (buf_rd) begin
                out_data_d = mem_data_q[rd_ptr_q];
                out_m_d    = mem_m_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
            end else begin
                out_data_d = in_data;
                out_m_d    = in_m;
            end
        end else if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (wr_en && !buf_rd) begin
            count_d = count_q + COUNT_ONE;
        end else if (!wr_en && buf_rd) begin
            count_d = count_q - COUNT_ONE;
        end

        // Dropped sample: full and nothing leaving this cycle.
        if (in_nd && full && !fire) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_m_q[wr_ptr_q]    <= in_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            out_data_q <= '0;
            out_m_q    <= '0;
            out_nd_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            out_data_q <= out_data_d;
            out_m_q    <= out_m_d;
            out_nd_q   <= out_nd_d;
            error_q    <= error_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_m     = out_m_q;
    assign out_nd    = out_nd_q;
    assign out_count = count_q;
    assign error     = error_q;

endmodule

// File: tb/tb_nothing_paced.sv
// ---------------------------------------------------------------------------
// tb_nothing_paced
//
// Four instances of nothing_paced with different SPACING/DEPTH settings share
// one stimulus stream. A queue-based reference model per instance predicts
// every output each cycle.
//   inst 0: SPACING=1, DEPTH=8
//   inst 1: SPACING=4, DEPTH=8
//   inst 2: SPACING=8, DEPTH=4
//   inst 3: SPACING=3, DEPTH=8
// ---------------------------------------------------------------------------
module tb_nothing_paced;

    typedef struct packed {
        logic [31:0] d;
        logic        m;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_nd;
    logic        in_m;

    logic [31:0] o_data [4];
    logic        o_m    [4];
    logic        o_nd   [4];
    logic [3:0]  o_cnt  [4];
    logic        o_err  [4];
    logic [2:0]  cnt2;

    int          sp  [4] = '{1, 4, 8, 3};
    int          dep [4] = '{8, 8, 4, 8};

    smp_t        mq [4][$];
    int          m_gap  [4];
    logic [31:0] m_data [4];
    logic        m_m    [4];
    logic        m_nd   [4];
    logic        m_err  [4];

    int          cyc;
    int          checks;
    int          fails;

    always #5 clk = ~clk;

    nothing_paced #(.WDTH(32), .MWDTH(1), .LOG_DEPTH(3), .DEPTH(8), .SPACING(1)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
        .out_data(o_data[0]), .out_nd(o_nd[0]), .out_m(o_m[0]),
        .out_count(o_cnt[0]), .error(o_err[0]));

    nothing_paced #(.WDTH(32), .MWDTH(1), .LOG_DEPTH(3), .DEPTH(8), .SPACING(4)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
        .out_data(o_data[1]), .out_nd(o_nd[1]), .out_m(o_m[1]),
        .out_count(o_cnt[1]), .error(o_err[1]));

    nothing_paced #(.WDTH(32), .MWDTH(1), .LOG_DEPTH(2), .DEPTH(4), .SPACING(8)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
        .out_data(o_data[2]), .out_nd(o_nd[2]), .out_m(o_m[2]),
        .out_count(cnt2), .error(o_err[2]));

    nothing_paced #(.WDTH(32), .MWDTH(1), .LOG_DEPTH(3), .DEPTH(8), .SPACING(3)) u3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
        .out_data(o_data[3]), .out_nd(o_nd[3]), .out_m(o_m[3]),
        .out_count(o_cnt[3]), .error(o_err[3]));

    assign o_cnt[2] = {1'b0, cnt2};

    // Apply one cycle of stimulus, advance past the rising edge, update the
    // reference model from the behavioural rules, then settle 1 time unit.
    task automatic tick(input logic nd, input logic [31:0] d, input logic m, input logic r);
        smp_t s;
        smp_t s_in;
        in_nd   = nd;
        in_data = d;
        in_m    = m;
        rst     = r;
        @(posedge clk);
        s_in.d = d;
        s_in.m = m;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                mq[k].delete();
                m_gap[k]  = 0;
                m_data[k] = '0;
                m_m[k]    = 1'b0;
                m_nd[k]   = 1'b0;
                m_err[k]  = 1'b0;
            end else if (m_gap[k] == 0 && (mq[k].size() > 0 || nd)) begin
                if (mq[k].size() > 0) begin
                    s = mq[k].pop_front();
                    m_data[k] = s.d;
                    m_m[k]    = s.m;
                    if (nd) mq[k].push_back(s_in);
                end else begin
                    m_data[k] = d;
                    m_m[k]    = m;
                end
                m_nd[k]  = 1'b1;
                m_gap[k] = sp[k] - 1;
            end else begin
                m_nd[k] = 1'b0;
                if (m_gap[k] > 0) m_gap[k]--;
                if (nd) begin
                    if (mq[k].size() == dep[k]) m_err[k] = 1'b1;
                    else mq[k].push_back(s_in);
                end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        tick(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        tick(1'b1, 32'h1234_5678, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_nd[k] !== 1'b0 || o_data[k] !== 32'd0 || o_m[k] !== 1'b0 ||
                o_cnt[k] !== 4'd0 || o_err[k] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset inst%0d: got nd=%b data=%h m=%b cnt=%0d err=%b, want all zero",
                         k, o_nd[k], o_data[k], o_m[k], o_cnt[k], o_err[k]);
            end
        end
    endtask

    task automatic test_passthrough;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) tick(1'b1, 32'(i + 1), 1'(i % 2), 1'b0);
            else        tick(1'b0, 32'd0, 1'b0, 1'b0);
            checks++;
            if (i < 10 && (o_nd[0] !== 1'b1 || o_data[0] !== 32'(i + 1) || o_m[0] !== 1'(i % 2))) begin
                fails++;
                $display("[TB] FAIL passthrough cyc %0d: got nd=%b data=%0d m=%b, want nd=1 data=%0d m=%0d",
                         cyc, o_nd[0], o_data[0], o_m[0], i + 1, i % 2);
            end
            checks++;
            if (o_cnt[0] !== 4'd0 || o_err[0] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL passthrough_cnt cyc %0d: got cnt=%0d err=%b, want 0/0", cyc, o_cnt[0], o_err[0]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_nd[k] !== m_nd[k] || o_data[k] !== m_data[k] || o_m[k] !== m_m[k] ||
                    o_cnt[k] !== 4'(mq[k].size()) || o_err[k] !== m_err[k]) begin
                    fails++;
                    $display("[TB] FAIL model inst%0d cyc %0d: got nd=%b d=%h m=%b c=%0d e=%b, want nd=%b d=%h m=%b c=%0d e=%b",
                             k, cyc, o_nd[k], o_data[k], o_m[k], o_cnt[k], o_err[k],
                             m_nd[k], m_data[k], m_m[k], mq[k].size(), m_err[k]);
                end
            end
        end
    endtask

    task automatic test_paced_burst;
        int exp_c [5] = '{1, 5, 9, 13, 17};
        int seen = 0;
        int peak = 0;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 5) tick(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            else       tick(1'b0, 32'd0, 1'b0, 1'b0);
            if (int'(o_cnt[1]) > peak) peak = int'(o_cnt[1]);
            if (o_nd[1] === 1'b1) begin
                checks++;
                if (seen >= 5 || cyc != exp_c[seen] || o_data[1] !== 32'hA0 + 32'(seen)) begin
                    fails++;
                    $display("[TB] FAIL paced_out #%0d: got cyc=%0d data=%h, want cyc=%0d data=%h",
                             seen, cyc, o_data[1], (seen < 5) ? exp_c[seen] : -1, 32'hA0 + 32'(seen));
                end
                seen++;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_nd[k] !== m_nd[k] || o_data[k] !== m_data[k] || o_m[k] !== m_m[k] ||
                    o_cnt[k] !== 4'(mq[k].size()) || o_err[k] !== m_err[k]) begin
                    fails++;
                    $display("[TB] FAIL model inst%0d cyc %0d: got nd=%b d=%h m=%b c=%0d e=%b, want nd=%b d=%h m=%b c=%0d e=%b",
                             k, cyc, o_nd[k], o_data[k], o_m[k], o_cnt[k], o_err[k],
                             m_nd[k], m_data[k], m_m[k], mq[k].size(), m_err[k]);
                end
            end
        end
        checks++;
        if (seen != 5 || peak != 3 || o_err[1] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL paced_summary: got outputs=%0d peak=%0d err=%b, want 5/3/0", seen, peak, o_err[1]);
        end
    endtask

    task automatic test_overflow;
        int exp_c [5] = '{1, 9, 17, 25, 33};
        int seen = 0;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 38; i++) begin
            if (i < 7) tick(1'b1, 32'(i), 1'b1, 1'b0);
            else       tick(1'b0, 32'd0, 1'b0, 1'b0);
            checks++;
            if (o_err[2] !== ((cyc >= 6) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("[TB] FAIL overflow_err cyc %0d: got %b, want %0d", cyc, o_err[2], cyc >= 6);
            end
            if (o_nd[2] === 1'b1) begin
                checks++;
                if (seen >= 5 || cyc != exp_c[seen] || o_data[2] !== 32'(seen)) begin
                    fails++;
                    $display("[TB] FAIL overflow_out #%0d: got cyc=%0d data=%0d, want cyc=%0d data=%0d",
                             seen, cyc, o_data[2], (seen < 5) ? exp_c[seen] : -1, seen);
                end
                seen++;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_nd[k] !== m_nd[k] || o_data[k] !== m_data[k] || o_m[k] !== m_m[k] ||
                    o_cnt[k] !== 4'(mq[k].size()) || o_err[k] !== m_err[k]) begin
                    fails++;
                    $display("[TB] FAIL model inst%0d cyc %0d: got nd=%b d=%h m=%b c=%0d e=%b, want nd=%b d=%h m=%b c=%0d e=%b",
                             k, cyc, o_nd[k], o_data[k], o_m[k], o_cnt[k], o_err[k],
                             m_nd[k], m_data[k], m_m[k], mq[k].size(), m_err[k]);
                end
            end
        end
        checks++;
        if (seen != 5) begin
            fails++;
            $display("[TB] FAIL overflow_total: got %0d outputs, want 5", seen);
        end
    endtask

    // Inst 2 is full (4 entries) when its gap expires on cycle 8; a new
    // sample on that cycle must be accepted without raising error.
    task automatic test_full_fire;
        logic [31:0] exp_d [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h18};
        int seen = 0;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 46; i++) begin
            if (i < 5 || i == 8) tick(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
            else                 tick(1'b0, 32'd0, 1'b0, 1'b0);
            if (cyc == 9) begin
                checks++;
                if (o_cnt[2] !== 4'd4 || o_err[2] !== 1'b0 || o_nd[2] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL full_fire cyc 9: got cnt=%0d err=%b nd=%b, want 4/0/1",
                             o_cnt[2], o_err[2], o_nd[2]);
                end
            end
            if (o_nd[2] === 1'b1) begin
                checks++;
                if (seen >= 6 || o_data[2] !== exp_d[seen]) begin
                    fails++;
                    $display("[TB] FAIL full_fire_order #%0d: got %h, want %h",
                             seen, o_data[2], (seen < 6) ? exp_d[seen] : 32'hX);
                end
                seen++;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_nd[k] !== m_nd[k] || o_data[k] !== m_data[k] || o_m[k] !== m_m[k] ||
                    o_cnt[k] !== 4'(mq[k].size()) || o_err[k] !== m_err[k]) begin
                    fails++;
                    $display("[TB] FAIL model inst%0d cyc %0d: got nd=%b d=%h m=%b c=%0d e=%b, want nd=%b d=%h m=%b c=%0d e=%b",
                             k, cyc, o_nd[k], o_data[k], o_m[k], o_cnt[k], o_err[k],
                             m_nd[k], m_data[k], m_m[k], mq[k].size(), m_err[k]);
                end
            end
        end
        checks++;
        if (seen != 6 || o_err[2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_fire_total: got %0d outputs err=%b, want 6/0", seen, o_err[2]);
        end
    endtask

    task automatic test_reset_mid_gap;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h50 + 32'(i), 1'b1, 1'b0);
        checks++;
        if (o_cnt[2] !== 4'd3) begin
            fails++;
            $display("[TB] FAIL midgap_pre: got cnt=%0d, want 3", o_cnt[2]);
        end
        tick(1'b1, 32'h99, 1'b1, 1'b1);
        checks++;
        if (o_nd[2] !== 1'b0 || o_cnt[2] !== 4'd0 || o_err[2] !== 1'b0 ||
            o_data[2] !== 32'd0 || o_m[2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midgap_reset: got nd=%b cnt=%0d err=%b data=%h m=%b, want all zero",
                     o_nd[2], o_cnt[2], o_err[2], o_data[2], o_m[2]);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 32'd0, 1'b0, 1'b0);
            checks++;
            if (o_nd[2] !== 1'b0 || o_cnt[2] !== 4'd0) begin
                fails++;
                $display("[TB] FAIL midgap_idle cyc %0d: got nd=%b cnt=%0d, want 0/0", cyc, o_nd[2], o_cnt[2]);
            end
        end
        tick(1'b1, 32'h77, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_nd[k] !== 1'b1 || o_data[k] !== 32'h77 || o_m[k] !== 1'b1) begin
                fails++;
                $display("[TB] FAIL midgap_next inst%0d: got nd=%b data=%h m=%b, want 1/77/1",
                         k, o_nd[k], o_data[k], o_m[k]);
            end
        end
    endtask

    task automatic test_random;
        int last = -1000;
        int outs = 0;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 10000; i++) begin
            tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if (o_nd[3] === 1'b1) begin
                checks++;
                if (cyc - last < 3) begin
                    fails++;
                    $display("[TB] FAIL random_spacing cyc %0d: got gap %0d, want >=3", cyc, cyc - last);
                end
                last = cyc;
                outs++;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_nd[k] !== m_nd[k] || o_data[k] !== m_data[k] || o_m[k] !== m_m[k] ||
                    o_cnt[k] !== 4'(mq[k].size()) || o_err[k] !== m_err[k]) begin
                    fails++;
                    $display("[TB] FAIL model inst%0d cyc %0d: got nd=%b d=%h m=%b c=%0d e=%b, want nd=%b d=%h m=%b c=%0d e=%b",
                             k, cyc, o_nd[k], o_data[k], o_m[k], o_cnt[k], o_err[k],
                             m_nd[k], m_data[k], m_m[k], mq[k].size(), m_err[k]);
                end
            end
        end
        checks++;
        if (outs < 3000) begin
            fails++;
            $display("[TB] FAIL random_activity: got %0d outputs, want >=3000", outs);
        end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        cyc     = 0;
        rst     = 1'b1;
        in_nd   = 1'b0;
        in_data = '0;
        in_m    = 1'b0;
        test_reset();
        test_passthrough();
        test_paced_burst();
        test_overflow();
        test_full_fire();
        test_reset_mid_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
